// File: rtl/hsv_hue_pipe.sv
// Two-stage valid/ready pipeline producing max/min/diff, a one-hot max-channel select and scaled channel differences.
// Optional macro HSV_SIGNED_EN: products are signed; otherwise they are |difference| * SCALE.
module hsv_hue_pipe #(
    parameter int W     = 8,
    parameter int SCALE = 43,
    parameter int PW    = W + 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         r,
    input  logic [W-1:0]         g,
    input  logic [W-1:0]         b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         max,
    output logic [W-1:0]         min,
    output logic [W-1:0]         diff,
    output logic                 max_r,
    output logic                 max_g,
    output logic                 max_b,
    output logic signed [PW-1:0] r_gx,
    output logic signed [PW-1:0] g_bx,
    output logic signed [PW-1:0] b_rx
);

    localparam logic signed [PW-1:0] SCALE_S = PW'(SCALE);
    localparam logic        [PW-1:0] SCALE_U = PW'(SCALE);

    logic                s1_valid;
    logic [W-1:0]        s1_max;
    logic [W-1:0]        s1_min;
    logic                s1_max_r;
    logic                s1_max_g;
    logic                s1_max_b;
    logic signed [W:0]   s1_rg;
    logic signed [W:0]   s1_gb;
    logic signed [W:0]   s1_br;

    logic                s2_ready;
    logic                sel_r;
    logic                sel_g;
    logic                sel_b;
    logic [W-1:0]        max_c;
    logic [W-1:0]        min_c;
    logic signed [W:0]   rg_c;
    logic signed [W:0]   gb_c;
    logic signed [W:0]   br_c;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    function automatic logic signed [PW-1:0] scale_diff(input logic signed [W:0] d);
`ifdef HSV_SIGNED_EN
        logic signed [PW-1:0] ext;
        ext = {{(PW-W-1){d[W]}}, d};
        return ext * SCALE_S;
`else
        logic [W:0] mag;
        mag = d[W] ? (W+1)'(-d) : d;
        return $signed({{(PW-W-1){1'b0}}, mag} * SCALE_U);
`endif
    endfunction

    // Ties resolve toward R, then G, so exactly one select bit is ever set.
    always_comb begin
        sel_r = (r >= g) && (r >= b);
        sel_g = !sel_r && (g >= b);
        sel_b = !sel_r && !sel_g;
        max_c = sel_r ? r : (sel_g ? g : b);
        min_c = r;
        if (g < min_c) min_c = g;
        if (b < min_c) min_c = b;
    end

    assign rg_c = $signed({1'b0, r}) - $signed({1'b0, g});
    assign gb_c = $signed({1'b0, g}) - $signed({1'b0, b});
    assign br_c = $signed({1'b0, b}) - $signed({1'b0, r});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_max   <= '0;
            s1_min   <= '0;
            s1_max_r <= 1'b0;
            s1_max_g <= 1'b0;
            s1_max_b <= 1'b0;
            s1_rg    <= '0;
            s1_gb    <= '0;
            s1_br    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_max   <= max_c;
                s1_min   <= min_c;
                s1_max_r <= sel_r;
                s1_max_g <= sel_g;
                s1_max_b <= sel_b;
                s1_rg    <= rg_c;
                s1_gb    <= gb_c;
                s1_br    <= br_c;
            end
        end
    end

    // Output registers only change when a valid stage-1 pixel moves forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            max       <= '0;
            min       <= '0;
            diff      <= '0;
            max_r     <= 1'b0;
            max_g     <= 1'b0;
            max_b     <= 1'b0;
            r_gx      <= '0;
            g_bx      <= '0;
            b_rx      <= '0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                max   <= s1_max;
                min   <= s1_min;
                diff  <= s1_max - s1_min;
                max_r <= s1_max_r;
                max_g <= s1_max_g;
                max_b <= s1_max_b;
                r_gx  <= scale_diff(s1_rg);
                g_bx  <= scale_diff(s1_gb);
                b_rx  <= scale_diff(s1_br);
            end
        end
    end

endmodule

// File: tb/tb_hsv_hue_pipe.sv
// Scoreboard bench for hsv_hue_pipe: expected bundles are queued at input handshake and compared at output handshake.
module tb_hsv_hue_pipe;

    localparam int W     = 8;
    localparam int SCALE = 43;
    localparam int PW    = W + 9;

    typedef struct {
        logic [W-1:0]  mx;
        logic [W-1:0]  mn;
        logic [W-1:0]  df;
        logic [2:0]    sel;
        logic [PW-1:0] rg;
        logic [PW-1:0] gb;
        logic [PW-1:0] br;
        int            cyc;
        bit            lat_chk;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  r;
    logic [W-1:0]  g;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  max;
    logic [W-1:0]  min;
    logic [W-1:0]  diff;
    logic          max_r;
    logic          max_g;
    logic          max_b;
    logic [PW-1:0] r_gx;
    logic [PW-1:0] g_bx;
    logic [PW-1:0] b_rx;

    exp_t        sb[$];
    int          checks;
    int          failures;
    int          cycle;
    int          n_out;
    bit          accepted;
    bit          seen_in_ready;
    bit          hold_valid;
    logic [95:0] held;
    bit          lat_mode;
    bit          rand_bp;

    hsv_hue_pipe #(.W(W), .SCALE(SCALE), .PW(PW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .r(r), .g(g), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .max(max), .min(min), .diff(diff),
        .max_r(max_r), .max_g(max_g), .max_b(max_b),
        .r_gx(r_gx), .g_bx(g_bx), .b_rx(b_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cycle);
        end
    endtask

    function automatic logic [PW-1:0] prod(input int d);
        int p;
`ifdef HSV_SIGNED_EN
        p = d * SCALE;
`else
        p = (d < 0 ? -d : d) * SCALE;
`endif
        return PW'(p);
    endfunction

    function automatic exp_t model(input int rr, input int gg, input int bb);
        exp_t e;
        int   mx;
        int   mn;
        mx = rr;
        if (gg > mx) mx = gg;
        if (bb > mx) mx = bb;
        mn = rr;
        if (gg < mn) mn = gg;
        if (bb < mn) mn = bb;
        e.mx  = W'(mx);
        e.mn  = W'(mn);
        e.df  = W'(mx - mn);
        e.sel = (rr == mx) ? 3'b100 : ((gg == mx) ? 3'b010 : 3'b001);
        e.rg  = prod(rr - gg);
        e.gb  = prod(gg - bb);
        e.br  = prod(bb - rr);
        e.cyc = 0;
        e.lat_chk = 1'b0;
        return e;
    endfunction

    function automatic logic [95:0] pack_out();
        return 96'({max, min, diff, max_r, max_g, max_b, r_gx, g_bx, b_rx});
    endfunction

    // Called just after a falling edge with this cycle's inputs already driven.
    task automatic tick();
        exp_t e;
        #1;
        accepted = 1'b0;
        if (hold_valid) begin
            checkOutput("stall_valid", 96'(out_valid), 96'(1));
            checkOutput("stall_data", pack_out(), held);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_out", 96'(sb.size()), 96'(1));
            end else begin
                e = sb.pop_front();
                checkOutput("max", 96'(max), 96'(e.mx));
                checkOutput("min", 96'(min), 96'(e.mn));
                checkOutput("diff", 96'(diff), 96'(e.df));
                checkOutput("sel", 96'({max_r, max_g, max_b}), 96'(e.sel));
                checkOutput("r_gx", 96'(r_gx), 96'(e.rg));
                checkOutput("g_bx", 96'(g_bx), 96'(e.gb));
                checkOutput("b_rx", 96'(b_rx), 96'(e.br));
                if (e.lat_chk) checkOutput("latency", 96'(cycle - e.cyc), 96'(2));
                n_out++;
            end
        end
        hold_valid    = out_valid && !out_ready;
        held          = pack_out();
        seen_in_ready = in_ready;
        if (in_valid && in_ready) begin
            e = model(int'(r), int'(g), int'(b));
            e.cyc = cycle;
            e.lat_chk = lat_mode;
            sb.push_back(e);
            accepted = 1'b1;
        end
        @(negedge clk);
        cycle++;
    endtask

    task automatic applyStimulus(input int rr, input int gg, input int bb);
        int n;
        in_valid = 1'b1;
        r = W'(rr);
        g = W'(gg);
        b = W'(bb);
        n = 0;
        do begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end while (!accepted && n < 50);
        if (!accepted) checkOutput("accept_timeout", 96'(accepted), 96'(1));
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        checkOutput("drain_empty", 96'(sb.size()), 96'(0));
    endtask

    initial begin
        int start_cyc;
        int start_out;
        checks = 0; failures = 0; cycle = 0; n_out = 0;
        hold_valid = 0; held = '0; lat_mode = 0; rand_bp = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        r = '0; g = '0; b = '0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_out_valid", 96'(out_valid), 96'(0));
        checkOutput("reset_outputs", pack_out(), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", 96'(in_ready), 96'(1));
        @(negedge clk);

        // Directed pixels with downstream always ready.
        lat_mode = 1;
        applyStimulus(200, 100, 50);
        applyStimulus(120, 120, 10);
        applyStimulus(255, 0, 0);
        applyStimulus(77, 77, 77);
        applyStimulus(10, 90, 90);
        applyStimulus(0, 0, 255);
        applyStimulus(0, 255, 0);
        drain();

        // Backpressure: two pixels fill the pipe, the third must wait.
        lat_mode = 0;
        out_ready = 1'b0;
        applyStimulus(30, 60, 90);
        applyStimulus(90, 60, 30);
        in_valid = 1'b1; r = 8'd5; g = 8'd250; b = 8'd128;
        tick();
        tick();
        checkOutput("in_ready_full", 96'(seen_in_ready), 96'(0));
        checkOutput("full_no_accept", 96'(accepted), 96'(0));
        out_ready = 1'b1;
        applyStimulus(5, 250, 128);
        drain();

        // Continuous random stream at full rate.
        lat_mode = 1;
        start_cyc = cycle;
        start_out = n_out;
        for (int i = 0; i < 100; i++)
            applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        checkOutput("stream_in_rate", 96'(cycle - start_cyc), 96'(100));
        drain();
        checkOutput("stream_out_count", 96'(n_out - start_out), 96'(100));

        // Random backpressure.
        lat_mode = 0;
        rand_bp = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        drain();
        rand_bp = 0;

        // Reset with two pixels in flight.
        out_ready = 1'b0;
        applyStimulus(200, 10, 100);
        applyStimulus(40, 180, 20);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", 96'(out_valid), 96'(0));
        checkOutput("midreset_outputs", pack_out(), 96'(0));
        sb.delete();
        hold_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("postreset_in_ready", 96'(in_ready), 96'(1));
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("no_stale", 96'(out_valid), 96'(0));
            @(negedge clk);
        end

        lat_mode = 1;
        applyStimulus(200, 100, 50);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
